// File: rtl/apb2axi_cmpl_sched_if.sv
// Completion scheduler bus: response_handler push side,
// SW status/consume side and RDF drain handshake.
interface apb2axi_cmpl_sched_if #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2**TAG_W
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             cmpl_valid;
    logic             cmpl_ready;
    logic [TAG_W-1:0] cmpl_tag;
    logic             cmpl_is_write;
    logic             cmpl_error;
    logic             head_valid;
    logic [TAG_W-1:0] head_tag;
    logic             head_is_write;
    logic             head_error;
    logic             consume_valid;
    logic [TAG_W-1:0] consume_tag;
    logic             rdf_req;
    logic [TAG_W-1:0] rdf_req_tag;
    logic             rdf_done;
    logic             pop_pulse;
    logic             consume_err;
    logic             dup_err;
    logic [CW-1:0]    count;

    modport master (
        output cmpl_valid, cmpl_tag, cmpl_is_write, cmpl_error,
        output consume_valid, consume_tag, rdf_done,
        input  cmpl_ready, head_valid, head_tag, head_is_write,
        input  head_error, rdf_req, rdf_req_tag, pop_pulse,
        input  consume_err, dup_err, count
    );

    modport slave (
        input  cmpl_valid, cmpl_tag, cmpl_is_write, cmpl_error,
        input  consume_valid, consume_tag, rdf_done,
        output cmpl_ready, head_valid, head_tag, head_is_write,
        output head_error, rdf_req, rdf_req_tag, pop_pulse,
        output consume_err, dup_err, count
    );
endinterface

// File: rtl/apb2axi_cmpl_sched.sv
// In-order completion queue with duplicate-tag rejection and
// RDF drain sequencing for read completions (PCLK domain).
module apb2axi_cmpl_sched #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2**TAG_W
) (
    input logic pclk,
    input logic presetn,
    apb2axi_cmpl_sched_if.slave bus
);
    localparam int NUM_TAGS = 2**TAG_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TAG_W + 2;

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]          state, state_nxt;
    logic [CW-1:0]       wr_ptr, rd_ptr, cnt, cnt_nxt;
    logic [EW-1:0]       mem [DEPTH];
    logic [NUM_TAGS-1:0] pending, pending_nxt;
    logic                full, can_take, push, dup, pop;
    logic                hit, drain_go, cons_bad;
    logic                head_valid_q, head_is_write_q, head_error_q;
    logic [TAG_W-1:0]    head_tag_q, rdf_req_tag_q;
    logic                rdf_req_q, pop_pulse_q, consume_err_q, dup_err_q;

    assign cnt  = wr_ptr - rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign hit = (state == S_PRESENT) && head_valid_q &&
                 bus.consume_valid &&
                 (bus.consume_tag == head_tag_q);
    assign drain_go = hit && !(head_is_write_q || head_error_q);
    assign cons_bad = bus.consume_valid && !hit;
    assign pop = (hit && (head_is_write_q || head_error_q)) ||
                 ((state == S_DRAIN) && bus.rdf_done);

    // A pop frees a slot in the same cycle, so a full queue may still accept
    assign can_take = bus.cmpl_valid && (!full || pop);
    assign push     = can_take && !pending[bus.cmpl_tag];
    assign dup      = can_take && pending[bus.cmpl_tag];

    assign cnt_nxt = cnt + {{(CW-1){1'b0}}, push}
                         - {{(CW-1){1'b0}}, pop};

    always_comb begin
        pending_nxt = pending;
        if (pop)
            pending_nxt[head_tag_q] = 1'b0;
        if (push)
            pending_nxt[bus.cmpl_tag] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (cnt != '0)
                    state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (pop)
                    state_nxt = (cnt_nxt != '0) ? S_PRESENT : S_EMPTY;
                else if (drain_go)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop)
                    state_nxt = (cnt_nxt != '0) ? S_PRESENT : S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {bus.cmpl_is_write, bus.cmpl_error,
                                    bus.cmpl_tag};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state           <= S_EMPTY;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            pending         <= '0;
            head_valid_q    <= 1'b0;
            head_is_write_q <= 1'b0;
            head_error_q    <= 1'b0;
            head_tag_q      <= '0;
            rdf_req_q       <= 1'b0;
            rdf_req_tag_q   <= '0;
            pop_pulse_q     <= 1'b0;
            consume_err_q   <= 1'b0;
            dup_err_q       <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (push)
                wr_ptr <= wr_ptr + CW'(1);
            if (pop)
                rd_ptr <= rd_ptr + CW'(1);
            if (rd_ptr != wr_ptr)
                {head_is_write_q, head_error_q, head_tag_q} <=
                    mem[rd_ptr[AW-1:0]];
            else
                {head_is_write_q, head_error_q, head_tag_q} <= '0;
            // Hidden for one cycle after a pop while the next head loads
            head_valid_q  <= (state_nxt == S_PRESENT) && !pop;
            rdf_req_q     <= drain_go;
            if (drain_go)
                rdf_req_tag_q <= head_tag_q;
            pop_pulse_q   <= pop;
            consume_err_q <= cons_bad;
            dup_err_q     <= dup;
        end
    end

    assign bus.cmpl_ready    = !full;
    assign bus.head_valid    = head_valid_q;
    assign bus.head_tag      = head_tag_q;
    assign bus.head_is_write = head_is_write_q;
    assign bus.head_error    = head_error_q;
    assign bus.rdf_req       = rdf_req_q;
    assign bus.rdf_req_tag   = rdf_req_tag_q;
    assign bus.pop_pulse     = pop_pulse_q;
    assign bus.consume_err   = consume_err_q;
    assign bus.dup_err       = dup_err_q;
    assign bus.count         = cnt;
endmodule

// File: tb/tb_apb2axi_cmpl_sched.sv
// Directed vector bench for apb2axi_cmpl_sched
// (TAG_W = 5, DEPTH = 16 so tag 16 exists while the queue is full).
module tb_apb2axi_cmpl_sched;
    localparam int TAG_W = 5;
    localparam int DEPTH = 16;
    localparam int NV    = 25;

    typedef struct packed {
        logic       hv;
        logic       hw;
        logic       he;
        logic [4:0] ht;
        logic       rq;
        logic [4:0] rt;
        logic       pp;
        logic       ce;
        logic       de;
        logic [4:0] cnt;
        logic       rdy;
    } out_t;

    typedef struct packed {
        logic       cv;
        logic [4:0] ct;
        logic       cw;
        logic       cerr;
        logic       sv;
        logic [4:0] st;
        logic       rd;
        out_t       exp;
    } vec_t;

    logic pclk;
    logic presetn;
    int   total;
    int   passed;

    apb2axi_cmpl_sched_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

    apb2axi_cmpl_sched #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic out_t o(input logic hv, input logic hw,
                               input logic he, input logic [4:0] ht,
                               input logic rq, input logic [4:0] rt,
                               input logic pp, input logic ce,
                               input logic de, input logic [4:0] cnt);
        out_t r;
        r.hv = hv; r.hw = hw; r.he = he; r.ht = ht;
        r.rq = rq; r.rt = rt; r.pp = pp; r.ce = ce;
        r.de = de; r.cnt = cnt; r.rdy = 1'b1;
        return r;
    endfunction

    function automatic vec_t v(input logic cv, input logic [4:0] ct,
                               input logic cw, input logic cerr,
                               input logic sv, input logic [4:0] st,
                               input logic rd, input out_t e);
        vec_t r;
        r.cv = cv; r.ct = ct; r.cw = cw; r.cerr = cerr;
        r.sv = sv; r.st = st; r.rd = rd; r.exp = e;
        return r;
    endfunction

    function automatic out_t grab();
        out_t g;
        g.hv  = bus.head_valid;
        g.hw  = bus.head_is_write;
        g.he  = bus.head_error;
        g.ht  = bus.head_tag;
        g.rq  = bus.rdf_req;
        g.rt  = bus.rdf_req_tag;
        g.pp  = bus.pop_pulse;
        g.ce  = bus.consume_err;
        g.de  = bus.dup_err;
        g.cnt = bus.count;
        g.rdy = bus.cmpl_ready;
        return g;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [4:0] ct,
                         input logic cw, input logic cerr,
                         input logic sv, input logic [4:0] st,
                         input logic rd);
        bus.cmpl_valid    = cv;
        bus.cmpl_tag      = ct;
        bus.cmpl_is_write = cw;
        bus.cmpl_error    = cerr;
        bus.consume_valid = sv;
        bus.consume_tag   = st;
        bus.rdf_done      = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_hv();
        for (int k = 0; k < 4; k++) begin
            if (bus.head_valid)
                break;
            tick();
        end
    endtask

    vec_t tbl [NV];

    initial begin
        logic [4:0] et;
        logic       bad;
        total  = 0;
        passed = 0;

        tbl[0]  = v(1, 3, 1, 0, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
        tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, o(1,1,0,3,0,0,0,0,0,1));
        tbl[2]  = v(0, 0, 0, 0, 1, 3, 0, o(0,1,0,3,0,0,1,0,0,0));
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0));
        tbl[4]  = v(1, 5, 0, 0, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,1));
        tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, o(1,0,0,5,0,0,0,0,0,1));
        tbl[6]  = v(0, 0, 0, 0, 1, 5, 0, o(0,0,0,5,1,5,0,0,0,1));
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 0, o(0,0,0,5,0,5,0,0,0,1));
        tbl[8]  = v(0, 0, 0, 0, 1, 5, 0, o(0,0,0,5,0,5,0,1,0,1));
        tbl[9]  = v(0, 0, 0, 0, 0, 0, 0, o(0,0,0,5,0,5,0,0,0,1));
        tbl[10] = v(0, 0, 0, 0, 0, 0, 1, o(0,0,0,5,0,5,1,0,0,0));
        tbl[11] = v(0, 0, 0, 0, 0, 0, 0, o(0,0,0,0,0,5,0,0,0,0));
        tbl[12] = v(1, 7, 1, 0, 0, 0, 0, o(0,0,0,0,0,5,0,0,0,1));
        tbl[13] = v(1, 7, 1, 0, 0, 0, 0, o(1,1,0,7,0,5,0,0,1,1));
        tbl[14] = v(0, 0, 0, 0, 0, 0, 0, o(1,1,0,7,0,5,0,0,0,1));
        tbl[15] = v(0, 0, 0, 0, 1, 9, 0, o(1,1,0,7,0,5,0,1,0,1));
        tbl[16] = v(0, 0, 0, 0, 0, 0, 0, o(1,1,0,7,0,5,0,0,0,1));
        tbl[17] = v(0, 0, 0, 0, 1, 7, 0, o(0,1,0,7,0,5,1,0,0,0));
        tbl[18] = v(0, 0, 0, 0, 0, 0, 0, o(0,0,0,0,0,5,0,0,0,0));
        tbl[19] = v(1, 4, 0, 1, 0, 0, 0, o(0,0,0,0,0,5,0,0,0,1));
        tbl[20] = v(0, 0, 0, 0, 0, 0, 0, o(1,0,1,4,0,5,0,0,0,1));
        tbl[21] = v(0, 0, 0, 0, 1, 4, 0, o(0,0,1,4,0,5,1,0,0,0));
        tbl[22] = v(0, 0, 0, 0, 0, 0, 0, o(0,0,0,0,0,5,0,0,0,0));
        tbl[23] = v(0, 0, 0, 0, 1, 4, 0, o(0,0,0,0,0,5,0,1,0,0));
        tbl[24] = v(0, 0, 0, 0, 0, 0, 1, o(0,0,0,0,0,5,0,0,0,0));

        presetn = 1'b0;
        idle();
        tick();
        tick();
        chk("reset", 64'(grab()), 64'(o(0,0,0,0,0,0,0,0,0,0)));
        presetn = 1'b1;

        // write, read-drain, duplicate, bad consume, error read
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].cv, tbl[i].ct, tbl[i].cw, tbl[i].cerr,
                  tbl[i].sv, tbl[i].st, tbl[i].rd);
            tick();
            chk($sformatf("vec%0d", i), 64'(grab()), 64'(tbl[i].exp));
        end
        idle();

        // fill to DEPTH, then push and pop together while full
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 5'(i), 1, 0, 0, 0, 0);
            tick();
        end
        chk("full_cnt", 64'(bus.count), 64'(16));
        chk("full_rdy", 64'(bus.cmpl_ready), 64'(0));
        drive(1, 16, 1, 0, 0, 0, 0);
        tick();
        chk("hold_cnt", 64'(bus.count), 64'(16));
        chk("hold_dup", 64'(bus.dup_err), 64'(0));
        chk("hold_head", 64'({bus.head_valid, bus.head_tag}),
            64'({1'b1, 5'd0}));
        drive(1, 16, 1, 0, 1, 0, 0);
        tick();
        chk("swap_cnt", 64'(bus.count), 64'(16));
        chk("swap_pop", 64'({bus.pop_pulse, bus.dup_err}),
            64'({1'b1, 1'b0}));
        idle();
        tick();
        chk("swap_head", 64'({bus.head_valid, bus.head_tag}),
            64'({1'b1, 5'd1}));

        // drain in arrival order
        for (int i = 0; i < DEPTH; i++) begin
            et = (i < DEPTH - 1) ? 5'(i + 1) : 5'd16;
            wait_hv();
            chk($sformatf("order%0d", i),
                64'({bus.head_valid, bus.head_tag}), 64'({1'b1, et}));
            drive(0, 0, 0, 0, 1, et, 0);
            tick();
            chk($sformatf("opop%0d", i), 64'(bus.pop_pulse), 64'(1));
            idle();
        end
        tick();
        chk("empty_cnt", 64'({bus.head_valid, bus.count}), 64'(0));

        // reset in the middle of a drain
        drive(1, 2, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        chk("t5_head", 64'({bus.head_valid, bus.head_tag}),
            64'({1'b1, 5'd2}));
        drive(0, 0, 0, 0, 1, 2, 0);
        tick();
        chk("t5_req", 64'({bus.rdf_req, bus.rdf_req_tag, bus.head_valid}),
            64'({1'b1, 5'd2, 1'b0}));
        idle();
        tick();
        presetn = 1'b0;
        #1;
        chk("t5_rst", 64'(grab()), 64'(o(0,0,0,0,0,0,0,0,0,0)));
        tick();
        presetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bad = bad | bus.rdf_req | bus.pop_pulse | bus.head_valid;
            tick();
        end
        chk("t5_quiet", 64'(bad), 64'(0));
        chk("t5_out", 64'(grab()), 64'(o(0,0,0,0,0,0,0,0,0,0)));
        drive(1, 2, 0, 0, 0, 0, 0);
        tick();
        idle();
        chk("t5_repush", 64'({bus.count, bus.dup_err}),
            64'({5'd1, 1'b0}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
